// File: rtl/gun_pkg.sv
// gun_pkg: shared definitions for the duck-hunt player turret.
//   - screen geometry (SCREEN_W / SCREEN_H)
//   - 6-bit pixel colours for turret body, bullets and muzzle flash
//   - in_box(): inclusive, unsigned 10-bit rectangle hit test
package gun_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [5:0] GUN_COLOR    = 6'b011100;
  localparam logic [5:0] BULLET_COLOR = 6'b111111;
  localparam logic [5:0] FLASH_COLOR  = 6'b110000;

  // True when (h,v) lies inside the w x bh box whose top-left is (x0,y0).
  // Bounds are inclusive and evaluated in 10-bit unsigned arithmetic.
  function automatic logic in_box(input logic [9:0] h, input logic [9:0] v,
                                  input logic [9:0] x0, input logic [9:0] y0,
                                  input logic [9:0] w, input logic [9:0] bh);
    return (h >= x0) && (h <= x0 + w - 10'd1) &&
           (v >= y0) && (v <= y0 + bh - 10'd1);
  endfunction

endpackage

// File: rtl/gun_bullet_slot.sv
// gun_bullet_slot: one projectile slot of the turret.
//   On tick: a load takes priority and places the bullet at (load_x,load_y);
//   otherwise an active bullet rises BULLET_STEP rows, freeing itself once
//   it can no longer rise a full step. x/y hold their last value when freed.
// Ports:
//   clk, reset       clock, async active-low reset
//   tick             physics tick (one cycle wide)
//   load             launch into this slot on this tick
//   load_x, load_y   launch position (left column, top row)
//   hcount, vcount   pixel being evaluated for the hit_pixel output
//   active, x, y     slot state
//   hit_pixel        (hcount,vcount) falls inside this active bullet
module gun_bullet_slot #(
  parameter int BULLET_STEP = 4,
  parameter int BULLET_W    = 3,
  parameter int BULLET_H    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [9:0] load_x,
  input  logic [9:0] load_y,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hit_pixel
);
  import gun_pkg::*;

  localparam logic [9:0] STEP = 10'(BULLET_STEP);
  localparam logic [9:0] BW   = 10'(BULLET_W);
  localparam logic [9:0] BH   = 10'(BULLET_H);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (tick) begin
      if (load) begin
        active <= 1'b1;
        x      <= load_x;
        y      <= load_y;
      end else if (active) begin
        if (y < STEP) active <= 1'b0;
        else          y      <= y - STEP;
      end
    end
  end

  assign hit_pixel = active && in_box(hcount, vcount, x, y, BW, BH);

endmodule

// File: rtl/gun_turret_ctrl.sv
// gun_turret_ctrl: player turret for the duck-hunt screen.
//   Moves left/right on a slow physics tick, launches up to N_BULLETS
//   vertical projectiles and draws turret body, barrel and bullets.
//   Optional build macro GUN_MUZZLE_FLASH_EN: barrel is drawn FLASH_COLOR
//   for 4 ticks after each launch (counter reloads on every launch).
// Ports:
//   clk, reset        pixel clock, async active-low reset
//   hcount, vcount    current pixel column / row
//   izq, der          move left / right (level; izq wins)
//   fire              fire button (level, rising edge detected here)
//   data, draw        registered pixel colour / ownership, 1 cycle latency
//   shot              1-cycle pulse coinciding with a new bullet going active
//   bullet_active     per-slot in-flight flags
//   bullet_x/y        slot i at [10i+9:10i]: bullet left column / top row
module gun_turret_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int GUN_W       = 63,
  parameter int BASE_TOP    = 466,
  parameter int BARREL_X    = 26,
  parameter int BARREL_W    = 11,
  parameter int BARREL_TOP  = 435,
  parameter int MOVE_DIV    = 100000,
  parameter int N_BULLETS   = 4,
  parameter int BULLET_STEP = 4,
  parameter int BULLET_W    = 3,
  parameter int BULLET_H    = 6,
  parameter int COOLDOWN    = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     izq,
  input  logic                     der,
  input  logic                     fire,
  output logic [5:0]               data,
  output logic                     draw,
  output logic                     shot,
  output logic [N_BULLETS-1:0]     bullet_active,
  output logic [10*N_BULLETS-1:0]  bullet_x,
  output logic [10*N_BULLETS-1:0]  bullet_y
);
  import gun_pkg::*;

  localparam int CW  = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
  localparam int CDW = $clog2(COOLDOWN + 1);
  localparam int SW  = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

  localparam logic [9:0] MAX_OFF   = 10'(SCREEN_W - GUN_W);
  localparam logic [9:0] MUZZLE_DX = 10'(BARREL_X + (BARREL_W - BULLET_W) / 2);
  localparam logic [9:0] LOAD_Y    = 10'(BARREL_TOP - BULLET_H);
  localparam logic [9:0] BASE_Y    = 10'(BASE_TOP);
  localparam logic [9:0] BASE_H    = 10'(SCREEN_H - BASE_TOP);
  localparam logic [9:0] GW        = 10'(GUN_W);
  localparam logic [9:0] BRL_DX    = 10'(BARREL_X);
  localparam logic [9:0] BRL_W     = 10'(BARREL_W);
  localparam logic [9:0] BRL_Y     = 10'(BARREL_TOP);
  localparam logic [9:0] BRL_H     = 10'(BASE_TOP - BARREL_TOP);

  logic [CW-1:0]        div_cnt;
  logic                 tick;
  logic [9:0]           offset;
  logic                 fire_q;
  logic                 fire_edge;
  logic                 pend;
  logic [CDW-1:0]       cooldown;
  logic [SW-1:0]        free_idx;
  logic                 have_free;
  logic                 launch;
  logic [N_BULLETS-1:0] load;
  logic [N_BULLETS-1:0] bullet_hit;
  logic [9:0]           load_x;
  logic                 base_hit;
  logic                 barrel_hit;
  logic [5:0]           barrel_color;

  // ---------------- physics tick ----------------
  assign tick = (div_cnt == CW'(MOVE_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  // ---------------- movement ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset <= '0;
    end else if (tick) begin
      if (izq) begin
        if (offset != 10'd0) offset <= offset - 10'd1;
      end else if (der && (offset < MAX_OFF)) begin
        offset <= offset + 10'd1;
      end
    end
  end

  // ---------------- fire edge / pending request ----------------
  // An edge seen on a tick cycle stays pending for the next tick; the
  // pending request from before is consumed (accepted or dropped) now.
  assign fire_edge = fire & ~fire_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      fire_q <= fire;
      pend   <= fire_edge | (pend & ~tick);
    end
  end

  // ---------------- slot arbiter ----------------
  // Uses the registered active flags, so a slot freeing on this tick is
  // still seen as busy and only becomes reusable on the following tick.
  always_comb begin
    free_idx  = '0;
    have_free = 1'b0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!bullet_active[i]) begin
        free_idx  = SW'(i);
        have_free = 1'b1;
      end
    end
  end

  assign launch = tick & pend & (cooldown == '0) & have_free;
  assign load_x = offset + MUZZLE_DX;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cooldown <= '0;
      shot     <= 1'b0;
    end else begin
      shot <= launch;
      if (launch)                         cooldown <= CDW'(COOLDOWN);
      else if (tick && cooldown != '0)    cooldown <= cooldown - CDW'(1);
    end
  end

  // ---------------- bullet slots ----------------
  for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
    assign load[i] = launch && (free_idx == SW'(i));

    gun_bullet_slot #(
      .BULLET_STEP (BULLET_STEP),
      .BULLET_W    (BULLET_W),
      .BULLET_H    (BULLET_H)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .load      (load[i]),
      .load_x    (load_x),
      .load_y    (LOAD_Y),
      .hcount    (hcount),
      .vcount    (vcount),
      .active    (bullet_active[i]),
      .x         (bullet_x[10*i +: 10]),
      .y         (bullet_y[10*i +: 10]),
      .hit_pixel (bullet_hit[i])
    );
  end

  // ---------------- muzzle flash ----------------
`ifdef GUN_MUZZLE_FLASH_EN
  logic [2:0] flash_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          flash_cnt <= '0;
    else if (launch)                     flash_cnt <= 3'd4;
    else if (tick && flash_cnt != 3'd0)  flash_cnt <= flash_cnt - 3'd1;
  end

  assign barrel_color = (flash_cnt != 3'd0) ? FLASH_COLOR : GUN_COLOR;
`else
  assign barrel_color = GUN_COLOR;
`endif

  // ---------------- pixel mux ----------------
  assign base_hit   = in_box(hcount, vcount, offset, BASE_Y, GW, BASE_H);
  assign barrel_hit = in_box(hcount, vcount, offset + BRL_DX, BRL_Y, BRL_W, BRL_H);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      draw <= 1'b0;
      data <= '0;
    end else begin
      draw <= base_hit | barrel_hit | (|bullet_hit);
      if (base_hit)          data <= GUN_COLOR;
      else if (barrel_hit)   data <= barrel_color;
      else if (|bullet_hit)  data <= BULLET_COLOR;
      else                   data <= '0;
    end
  end

endmodule

// File: tb/tb_gun_turret_ctrl.sv
// Testbench for gun_turret_ctrl (MOVE_DIV=4, default build).
// A reference model advances once per clock; every cycle it queues the
// expected pixel and slot state, and every launch it queues a shot record.
// A monitor on the falling edge pops and compares those against the DUT.
module tb_gun_turret_ctrl;
  import gun_pkg::*;

  localparam int N    = 4;
  localparam int MDIV = 4;
  localparam int CD   = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [9:0]     hcount = '0, vcount = '0;
  logic           izq = 1'b0, der = 1'b0, fire = 1'b0;
  logic [5:0]     data;
  logic           draw, shot;
  logic [N-1:0]   bullet_active;
  logic [10*N-1:0] bullet_x, bullet_y;

  gun_turret_ctrl #(.MOVE_DIV(MDIV), .N_BULLETS(N), .COOLDOWN(CD)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .izq(izq), .der(der), .fire(fire), .data(data), .draw(draw),
    .shot(shot), .bullet_active(bullet_active),
    .bullet_x(bullet_x), .bullet_y(bullet_y));

  always #5 clk = ~clk;

  typedef struct {
    logic            draw;
    logic [5:0]      data;
    logic [N-1:0]    act;
    logic [10*N-1:0] bx;
    logic [10*N-1:0] by;
  } exp_t;

  typedef struct { int slot; int x; int y; } shot_t;

  exp_t  pix_q[$];
  shot_t shot_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // ---------------- reference model state ----------------
  int m_off, m_cnt, m_cd;
  bit m_fq, m_pend;
  int m_act[N], m_x[N], m_y[N];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_off = 0; m_cnt = 0; m_cd = 0; m_fq = 0; m_pend = 0;
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
  endtask

  // Expected pixel from the geometry rules, with plain integer arithmetic.
  task automatic model_pixel(input int h, input int v, output logic d, output logic [5:0] c);
    bit gun, bul;
    gun = (v >= 466 && v <= 479 && h >= m_off && h <= m_off + 62) ||
          (v >= 435 && v <= 465 && h >= m_off + 26 && h <= m_off + 36);
    bul = 0;
    for (int i = 0; i < N; i++)
      if (m_act[i] && h >= m_x[i] && h < m_x[i] + 3 && v >= m_y[i] && v < m_y[i] + 6) bul = 1;
    d = gun | bul;
    c = gun ? GUN_COLOR : (bul ? BULLET_COLOR : 6'd0);
  endtask

  // Called just after each rising edge, with the inputs that edge sampled.
  task automatic model_edge();
    exp_t  e;
    shot_t s;
    bit    tk, fe;
    int    ls;
    if (!reset) begin
      model_reset();
      e.draw = 0; e.data = 0;
    end else begin
      model_pixel(int'(hcount), int'(vcount), e.draw, e.data);
      tk = (m_cnt == MDIV - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      fe = fire && !m_fq;
      m_fq = fire;
      if (tk) begin
        ls = -1;
        if (m_pend && m_cd == 0)
          for (int i = 0; i < N; i++) if (!m_act[i] && ls < 0) ls = i;
        for (int i = 0; i < N; i++)
          if (m_act[i]) begin
            if (m_y[i] < 4) m_act[i] = 0;
            else m_y[i] -= 4;
          end
        if (ls >= 0) begin
          m_act[ls] = 1; m_x[ls] = m_off + 30; m_y[ls] = 429; m_cd = CD;
          s.slot = ls; s.x = m_x[ls]; s.y = 429;
          shot_q.push_back(s);
        end else if (m_cd > 0) m_cd--;
        if (izq) begin
          if (m_off > 0) m_off--;
        end else if (der && m_off < 577) m_off++;
        m_pend = fe;
      end else begin
        m_pend = m_pend | fe;
      end
    end
    for (int i = 0; i < N; i++) begin
      e.act[i]        = m_act[i][0];
      e.bx[10*i +: 10] = 10'(m_x[i]);
      e.by[10*i +: 10] = 10'(m_y[i]);
    end
    pix_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t  e;
    shot_t s;
    forever begin
      @(negedge clk);
      if (pix_q.size() > 0) begin
        e = pix_q.pop_front();
        chk("draw", 64'(draw), 64'(e.draw));
        chk("data", 64'(data), 64'(e.data));
        chk("bullet_active", 64'(bullet_active), 64'(e.act));
        chk("bullet_x", 64'(bullet_x), 64'(e.bx));
        chk("bullet_y", 64'(bullet_y), 64'(e.by));
      end
      if (shot) begin
        if (shot_q.size() == 0) begin
          chk("unexpected_shot", 64'(shot), 64'd0);
        end else begin
          s = shot_q.pop_front();
          chk("shot_slot_active", 64'(bullet_active[s.slot]), 64'd1);
          chk("shot_x", 64'(bullet_x[10*s.slot +: 10]), 64'(s.x));
          chk("shot_y", 64'(bullet_y[10*s.slot +: 10]), 64'(s.y));
        end
      end else if (shot_q.size() != 0) begin
        chk("missing_shot", 64'(shot), 64'd1);
        void'(shot_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int clamp0(input int a);
    return (a < 0) ? 0 : a;
  endfunction

  task automatic pick_pixel();
    int k, s;
    k = $urandom_range(0, 3);
    if (k <= 1) begin
      hcount = 10'(clamp0(m_off - 3 + $urandom_range(0, 70)));
      vcount = 10'($urandom_range(428, 482));
    end else if (k == 2) begin
      s = $urandom_range(0, N - 1);
      hcount = 10'(clamp0(m_x[s] - 2 + $urandom_range(0, 6)));
      vcount = 10'(clamp0(m_y[s] - 2 + $urandom_range(0, 9)));
    end else begin
      hcount = 10'($urandom_range(0, 1023));
      vcount = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      pick_pixel();
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic ticks(input int n);
    cyc(n * MDIV);
  endtask

  task automatic probe(input int h, input int v);
    hcount = 10'(h); vcount = 10'(v);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic fire_pulse();
    fire = 1'b1; cyc(2); fire = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_draw", 64'(draw), 64'd0);
    chk("reset_data", 64'(data), 64'd0);
    chk("reset_shot", 64'(shot), 64'd0);
    chk("reset_active", 64'(bullet_active), 64'd0);
    cyc(3);
    reset = 1'b1;

    // right limit, then izq overriding der
    der = 1'b1; ticks(600);
    probe(639, 470); probe(576, 470); probe(640, 470);
    izq = 1'b1; ticks(10);
    der = 1'b0;
    // left limit, no wrap
    ticks(600);
    probe(0, 470); probe(1023, 470); probe(62, 479);
    izq = 1'b0;
    // offset 100, single shot and full flight
    der = 1'b1; ticks(100); der = 1'b0;
    fire_pulse();
    ticks(3);
    probe(130, 440);
    ticks(115);
    // slot exhaustion
    for (int k = 0; k < 5; k++) begin fire_pulse(); ticks(25); end
    ticks(120);
    // cooldown
    fire_pulse(); ticks(3); fire_pulse(); ticks(18); fire_pulse(); ticks(10);
    // reset mid-flight
    fire_pulse(); ticks(10);
    reset = 1'b0;
    #1;
    chk("midreset_active", 64'(bullet_active), 64'd0);
    chk("midreset_shot", 64'(shot), 64'd0);
    model_reset();
    cyc(2);
    reset = 1'b1;
    // randomized play
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) izq = ~izq;
      if ($urandom_range(0, 15) == 0) der = ~der;
      if ($urandom_range(0, 7) == 0)  fire = ~fire;
      cyc(1);
    end
    fire = 1'b0; izq = 1'b0; der = 1'b0;
    cyc(4);
    chk("queues_drained", 64'(shot_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
